// File: rtl/ps2_rx_interface.sv
// ps2_rx_interface: receive-only PS/2 frame decoder with clock glitch filter and
// inactivity timeout. Rev 1.0 - initial release.
`default_nettype none

module ps2_rx_interface #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        ps2_clock,
  inout  wire        ps2_data,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_s_q;
  logic [1:0]    data_s_q;
  logic [FW-1:0] filt_cnt_q;
  logic          filt_q;
  logic          filt_prev_q;
  logic          fall_q;

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [7:0]    key_q;
  logic          pressed_q;

  // Synchronizers, glitch filter and registered falling-edge detect.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s_q     <= 2'b11;
      data_s_q    <= 2'b11;
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_s_q     <= {clk_s_q[0], ps2_clock};
      data_s_q    <= {data_s_q[0], ps2_data};
      filt_prev_q <= filt_q;
      fall_q      <= filt_prev_q & ~filt_q;
      if (clk_s_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q     <= clk_s_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  // Frame decoder; the timeout abort takes precedence over a stale frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      key_q     <= 8'h00;
      pressed_q <= 1'b0;
    end else begin
      pressed_q <= 1'b0;
      if (state_q == IDLE || fall_q) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (state_q != IDLE && !fall_q && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        tmo_q     <= '0;
      end else if (fall_q) begin
        case (state_q)
          IDLE: begin
            if (!data_s_q[1]) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {data_s_q[1], shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            par_q   <= data_s_q[1];
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (data_s_q[1] && ((^shift_q) ^ par_q)) begin
              key_q     <= shift_q;
              pressed_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ps2_key_data    = key_q;
  assign ps2_out         = key_q;
  assign ps2_key_pressed = pressed_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_interface.sv
// tb_ps2_rx_interface: directed and randomized PS/2 frames checked against a
// byte-level reference model. Rev 1.0 - initial release.
`default_nettype none

module tb_ps2_rx_interface;

  localparam int FL   = 8;
  localparam int TMO  = 400;
  localparam int HALF = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;
  wire  ps2_clock_w;
  wire  ps2_data_w;
  logic [7:0] key_data;
  logic       key_pressed;
  logic [7:0] out_byte;

  assign ps2_clock_w = ps2c;
  assign ps2_data_w  = ps2d;

  ps2_rx_interface #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clock           (clk),
    .reset           (rst),
    .ps2_clock       (ps2_clock_w),
    .ps2_data        (ps2_data_w),
    .ps2_key_data    (key_data),
    .ps2_key_pressed (key_pressed),
    .ps2_out         (out_byte)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_strobe = 0;
  int strobe_cyc = 0;
  logic [7:0] last_key = 8'h00;
  logic [7:0] model_out = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (key_pressed === 1'b1) begin
      n_strobe   = n_strobe + 1;
      strobe_cyc = cyc;
      last_key   = key_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of start/data/parity/stop; c0 is the cycle index of the
  // first rising edge that sees the stop-bit low level.
  task automatic send_frame(input logic [7:0] b, input bit par, input bit stp,
                            input int nbits, output int c0);
    bit bits [11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9]  = par;
    bits[10] = stp;
    c0 = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2d = bits[i];
      wait_cyc(HALF / 2);
      ps2c = 1'b0;
      if (i == 10) begin
        @(posedge clk);
        #1;
        c0 = cyc;
      end
      wait_cyc(HALF);
      ps2c = 1'b1;
      wait_cyc(HALF / 2);
    end
    ps2d = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit par, input bit stp);
    int s0;
    int c0;
    bit acc;
    s0  = n_strobe;
    acc = stp && (((^b) ^ par) == 1'b1);
    send_frame(b, par, stp, 11, c0);
    wait_cyc(4);
    if (acc) model_out = b;
    check({tag, "_strobes"}, n_strobe - s0, acc ? 1 : 0);
    if (acc) begin
      check({tag, "_key"}, last_key, b);
      check({tag, "_latency"}, strobe_cyc - c0, FL + 3);
    end
    check({tag, "_out"}, out_byte, model_out);
  endtask

  initial begin
    int s0;
    int c0;
    logic [7:0] rb;
    int mode;

    rst = 1'b1;
    wait_cyc(5);
    @(posedge clk); #1;
    check("rst_key", key_data, 8'h00);
    check("rst_out", out_byte, 8'h00);
    check("rst_strobe", key_pressed, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(20);

    run_frame("f1C", 8'h1C, 1'b0, 1'b1);
    run_frame("fF0", 8'hF0, 1'b1, 1'b1);
    run_frame("f1C_b2b", 8'h1C, 1'b0, 1'b1);
    run_frame("badpar", 8'h1C, 1'b1, 1'b1);
    run_frame("badstop", 8'hA7, 1'b1, 1'b0);

    s0 = n_strobe;
    @(negedge clk);
    ps2d = 1'b0;
    ps2c = 1'b0;
    wait_cyc(1);
    ps2c = 1'b1;
    wait_cyc(30);
    ps2c = 1'b0;
    wait_cyc(5);
    ps2c = 1'b1;
    wait_cyc(30);
    ps2d = 1'b1;
    wait_cyc(30);
    check("glitch_strobes", n_strobe - s0, 0);
    check("glitch_out", out_byte, model_out);
    run_frame("after_glitch", 8'h3B, 1'b0, 1'b1);

    s0 = n_strobe;
    send_frame(8'hFF, 1'b1, 1'b1, 4, c0);
    wait_cyc(TMO + 10);
    check("tmo_strobes", n_strobe - s0, 0);
    run_frame("f29", 8'h29, 1'b0, 1'b1);

    send_frame(8'hB6, 1'b0, 1'b1, 6, c0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_key", key_data, 8'h00);
    check("midrst_out", out_byte, 8'h00);
    check("midrst_strobe", key_pressed, 1'b0);
    model_out = 8'h00;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20);
    run_frame("f5A", 8'h5A, 1'b1, 1'b1);

    for (int k = 0; k < 12; k++) begin
      rb   = 8'($urandom);
      mode = $urandom_range(0, 5);
      run_frame("rand", rb, (~^rb) ^ (mode == 0), mode != 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
